// File: rtl/digit_serial_adder_pkg.sv
// Shared types and constants for the digit-serial adder: FSM states,
// digit width and the digit-counter width helper.
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_BITS = 2;

    // Counter must index W/2 digits; a single-digit build still needs one bit.
    function automatic int cnt_width(input int w);
        int digits;
        digits = w / SLICE_BITS;
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Operand and result handshakes of the digit-serial adder.
// The master drives operands and out_ready; the slave is the adder.
interface digit_serial_adder_if #(
    parameter int W = 16
);
    import digit_serial_adder_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );

endinterface

// File: rtl/digit_serial_adder_add2_slice.sv
// Combinational 2-bit adder slice: carry-in a, bit pairs (b,c) and (d,e),
// sum bits f and g, carry-out h.
module add2_slice (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    output logic f,
    output logic g,
    output logic h
);
    import digit_serial_adder_pkg::*;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    logic m;

    assign f = a ^ b ^ c;
    assign m = maj(a, b, c);
    assign g = m ^ d ^ e;
    assign h = maj(m, d, e);

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle W-bit adder: streams operands LSB first through one 2-bit
// slice, registering the inter-digit carry, with valid/ready on both sides.
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    digit_serial_adder_if.slave  bus
);

    localparam int DIGITS = W / SLICE_BITS;
    localparam int CW     = cnt_width(W);

    generate
        if ((W < SLICE_BITS) || ((W % SLICE_BITS) != 0)) begin : g_bad_width
            $error("digit_serial_adder: W must be even and at least 2");
        end
    endgenerate

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  sum_sh;
    logic [W-1:0]  digit_ext;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          last_digit;
    logic          f;
    logic          g;
    logic          h;

    add2_slice u_slice (
        .a (carry),
        .b (a_sh[0]),
        .c (b_sh[0]),
        .d (a_sh[1]),
        .e (b_sh[1]),
        .f (f),
        .g (g),
        .h (h)
    );

    assign last_digit = (cnt == CW'(DIGITS - 1));
    assign digit_ext  = W'({g, f});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (last_digit)    state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs depend on state and registers only; the result is masked
    // outside DONE so partial sums never leak out.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_sum   = '0;
        bus.out_cout  = 1'b0;
        case (state)
            IDLE: bus.in_ready = 1'b1;
            DONE: begin
                bus.out_valid = 1'b1;
                bus.out_sum   = sum_sh;
                bus.out_cout  = carry;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh  <= bus.in_a;
                        b_sh  <= bus.in_b;
                        carry <= bus.in_cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    // New digit enters at the top; after W/2 shifts it lands in place.
                    a_sh   <= a_sh >> SLICE_BITS;
                    b_sh   <= b_sh >> SLICE_BITS;
                    sum_sh <= (sum_sh >> SLICE_BITS) | (digit_ext << (W - SLICE_BITS));
                    carry  <= h;
                    cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder at W=16, W=2 and W=64,
// compared against a plain-arithmetic model of A + B + cin.
module tb_digit_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    digit_serial_adder_if #(.W(16)) bus16 ();
    digit_serial_adder_if #(.W(2))  bus2  ();
    digit_serial_adder_if #(.W(64)) bus64 ();

    digit_serial_adder #(.W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
    digit_serial_adder #(.W(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2.slave));
    digit_serial_adder #(.W(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64.slave));

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {cout, sum} of a w-bit add is simply the exact integer sum.
    function automatic logic [127:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                             input logic cin);
        return 128'(a) + 128'(b) + 128'(cin);
    endfunction

    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic cin);
        int guard;
        guard = 0;
        while (!bus16.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("start16_timeout", 0, 1);
        bus16.in_a     = a;
        bus16.in_b     = b;
        bus16.in_cin   = cin;
        bus16.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus16.in_valid = 1'b0;
    endtask

    task automatic wait16(output int lat);
        lat = 0;
        while (!bus16.out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic finish16(input string tag);
        bus16.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus16.out_ready = 1'b0;
        check({tag, "_ready_after"}, bus16.in_ready, 1);
        check({tag, "_valid_after"}, bus16.out_valid, 0);
    endtask

    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] exp_sum, input logic exp_cout,
                        input int hold);
        int lat;
        start16(a, b, cin);
        wait16(lat);
        check({tag, "_lat"}, lat, 8);
        check({tag, "_sum"}, bus16.out_sum, exp_sum);
        check({tag, "_cout"}, bus16.out_cout, exp_cout);
        repeat (hold) @(negedge clk);
        finish16(tag);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] r;
        logic [63:0]  ra, rb;
        logic         rc;
        int           lat;
        int           cyc;
        int           acc[$];

        bus16.in_valid = 0; bus16.in_a = '0; bus16.in_b = '0; bus16.in_cin = 0; bus16.out_ready = 0;
        bus2.in_valid  = 0; bus2.in_a  = '0; bus2.in_b  = '0; bus2.in_cin  = 0; bus2.out_ready  = 0;
        bus64.in_valid = 0; bus64.in_a = '0; bus64.in_b = '0; bus64.in_cin = 0; bus64.out_ready = 0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", bus16.in_ready, 1);
        check("reset_out_valid", bus16.out_valid, 0);
        check("reset_out_sum", bus16.out_sum, 0);
        check("reset_out_cout", bus16.out_cout, 0);

        op16("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0);
        op16("ripple1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0);
        op16("ripple2", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0);

        // Stall in DONE with foreign operands offered throughout RUN/DONE.
        start16(16'hABCD, 16'h1111, 1'b0);
        bus16.in_a = 16'h0F0F; bus16.in_b = 16'h7777; bus16.in_cin = 1'b1;
        bus16.in_valid = 1'b1;
        wait16(lat);
        check("stall_lat", lat, 8);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", bus16.out_valid, 1);
            check("stall_sum", bus16.out_sum, 16'hBCDE);
            check("stall_cout", bus16.out_cout, 0);
            check("stall_in_ready", bus16.in_ready, 0);
            @(posedge clk);
            @(negedge clk);
        end
        bus16.in_valid = 1'b0;
        finish16("stall");

        // Reset after three digits of a RUN.
        start16(16'h5A5A, 16'h0F0F, 1'b1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_run_valid", bus16.out_valid, 0);
        check("rst_run_sum", bus16.out_sum, 0);
        check("rst_run_cout", bus16.out_cout, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_run_in_ready", bus16.in_ready, 1);
        op16("carry_cleared", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 0);

        // Reset while a result is being presented drops it without a clock edge.
        start16(16'hFFFF, 16'h0002, 1'b0);
        wait16(lat);
        check("rst_done_pre_valid", bus16.out_valid, 1);
        check("rst_done_pre_sum", bus16.out_sum, 16'h0001);
        rst = 1'b1;
        #1;
        check("rst_done_valid", bus16.out_valid, 0);
        check("rst_done_sum", bus16.out_sum, 0);
        check("rst_done_cout", bus16.out_cout, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_done_in_ready", bus16.in_ready, 1);
        check("rst_done_still_idle", bus16.out_valid, 0);

        // Back-to-back: in_valid and out_ready held high.
        bus16.in_a = 16'h1357; bus16.in_b = 16'h2468; bus16.in_cin = 1'b1;
        bus16.in_valid = 1'b1;
        bus16.out_ready = 1'b1;
        cyc = 0;
        repeat (35) begin
            if (bus16.in_ready) acc.push_back(cyc);
            if (bus16.out_valid) begin
                check("b2b_sum", bus16.out_sum, 16'h37C0);
                check("b2b_cout", bus16.out_cout, 0);
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        bus16.in_valid = 1'b0;
        repeat (15) @(negedge clk);
        bus16.out_ready = 1'b0;
        check("b2b_accepts", (acc.size() >= 3) ? 1 : 0, 1);
        if (acc.size() >= 3) begin
            check("b2b_ii_1", acc[1] - acc[0], 10);
            check("b2b_ii_2", acc[2] - acc[1], 10);
        end

        // Random regression at W=16 with random result back-pressure.
        for (int i = 0; i < 25; i++) begin
            ra = 64'($urandom_range(0, 16'hFFFF));
            rb = 64'($urandom_range(0, 16'hFFFF));
            rc = 1'($urandom_range(0, 1));
            r  = ref_add(ra, rb, rc);
            op16("rand16", ra[15:0], rb[15:0], rc, r[15:0], r[16], $urandom_range(0, 3));
        end

        // Exhaustive W=2: single-digit build, one-cycle latency.
        for (int i = 0; i < 32; i++) begin
            int v;
            v = i;
            ra = 64'(v[1:0]);
            rb = 64'(v[3:2]);
            rc = v[4];
            r  = ref_add(ra, rb, rc);
            check("w2_in_ready", bus2.in_ready, 1);
            bus2.in_a = ra[1:0]; bus2.in_b = rb[1:0]; bus2.in_cin = rc;
            bus2.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus2.in_valid = 1'b0;
            lat = 0;
            while (!bus2.out_valid && lat < 10) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            check("w2_lat", lat, 1);
            check("w2_result", {bus2.out_cout, bus2.out_sum}, r[2:0]);
            bus2.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus2.out_ready = 1'b0;
        end

        // Random regression at W=64, starting with a full-length ripple.
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin
                ra = '1; rb = 64'd1; rc = 1'b0;
            end else begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                rc = 1'($urandom_range(0, 1));
            end
            r = ref_add(ra, rb, rc);
            check("w64_in_ready", bus64.in_ready, 1);
            bus64.in_a = ra; bus64.in_b = rb; bus64.in_cin = rc;
            bus64.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus64.in_valid = 1'b0;
            lat = 0;
            while (!bus64.out_valid && lat < 60) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            check("w64_lat", lat, 32);
            check("w64_sum", bus64.out_sum, r[63:0]);
            check("w64_cout", bus64.out_cout, r[64]);
            bus64.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus64.out_ready = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Multi-cycle W-bit adder that streams two operands and a carry-in through a combinational 2-bit adder slice, two bits per clock, LSB first. It is the sequencing stage directly upstream of the 2-bit slice. It latches operands through a valid/ready handshake, feeds the slice one digit per cycle, registers the slice's carry between digits, and presents the assembled sum and carry-out on a second valid/ready handshake.

## Interface
Parameters:
- W, 16: operand width in bits. Must be even and ≥ 2; elaboration fails otherwise.

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands and carry-in are valid
- in_ready  out  1  block can accept operands
- in_a  in  W  operand A
- in_b  in  W  operand B
- in_cin  in  1  carry-in
- out_valid  out  1  sum and carry-out are valid
- out_ready  in  1  downstream accepts the result
- out_sum  out  W  A + B + cin, modulo 2^W
- out_cout  out  1  carry-out of the W-bit sum

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. If in_valid is high, the block latches in_a and in_b into shift registers, loads carry with in_cin, clears the digit counter and enters RUN.
- RUN: each cycle, slice digit k drives the slice inputs:
  - a = carry
  - b = A[2k], c = B[2k]
  - d = A[2k+1], e = B[2k+1]
- Slice outputs are captured on the clock edge:
  - f → sum[2k]
  - g → sum[2k+1]
  - h → carry
- Operand registers shift right by 2. The sum register shifts right by 2 with the new digit entering at the top.
- The counter runs 0 … W/2−1. On the edge that captures digit W/2−1, the block enters DONE.
- DONE: out_valid=1. out_sum and out_cout (final carry) are held stable. On out_valid && out_ready the block returns to IDLE.
- in_ready is 0 in RUN and DONE. in_valid in those states is ignored and no operands are latched.
- The carry register is never exposed except as out_cout in DONE.
- Reset (asserted at any time, including mid-RUN or in DONE):
  - state = IDLE, counter = 0, carry = 0, operand and sum registers = 0
  - out_valid=0, out_sum=0, out_cout=0; in_ready=1 once reset is released
  - any partial result is discarded

## Timing
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_cout=0.
- Accept edge = edge T with IDLE && in_valid.
- Digits are computed on edges T+1 … T+W/2. out_valid rises after edge T+W/2 (latency W/2 cycles; 8 for W=16).
- If out_ready is high in the first DONE cycle, the result transfers on edge T+W/2+1. in_ready is 1 in the following cycle.
- Minimum initiation interval: W/2+2 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from in_* or out_ready to any output.

## Structure
- Shared package:
  - state enum (IDLE, RUN, DONE)
  - constant SLICE_BITS = 2
  - counter width function clog2(W/2), minimum 1
- One sub-module: add2_slice. It is purely combinational, with inputs a, b, c, d, e and outputs f, g, h:
  - f = a^b^c
  - m = maj(a,b,c)
  - g = m^d^e
  - h = maj(m,d,e)
- The top level instantiates exactly one add2_slice.

## Test plan
All scenarios use W=16 unless noted.
1. 0x1234 + 0x4321, cin=0 → out_valid rises 8 cycles after accept; out_sum=0x5555, out_cout=0.
2. 0xFFFF + 0x0001, cin=0 → out_sum=0x0000, out_cout=1. 0xFFFF + 0xFFFF, cin=1 → out_sum=0xFFFF, out_cout=1. These check carry rippling through every digit.
3. out_ready held low for 5 cycles in DONE → out_valid, out_sum and out_cout are stable throughout, and in_ready=0. A different operand set with in_valid=1 during RUN/DONE is not accepted. Raising out_ready returns the block to IDLE on the next edge.
4. rst asserted after digit 3 of a RUN → outputs take their reset values asynchronously, and in_ready=1 after release. A following 0x0000 + 0x0000, cin=1 → out_sum=0x0001, out_cout=0, proving the carry was cleared.
5. Back-to-back operations with in_valid and out_ready held high → the measured initiation interval is 10 cycles.
6. W=2 build, exhaustive check of all 32 {a, b, cin} combinations → latency 1 cycle, and {out_cout, out_sum} = a + b + cin. Random regression at W=16 and W=64 is checked against a reference-model sum.
